// File: rtl/pattern_unpacker.sv
// pattern_unpacker: takes one masked aggregate per handshake and streams the
// masked-in elements out one per beat, lowest index first.
module pattern_unpacker #(
  parameter  int ELEM_W = 8,
  parameter  int N_ELEM = 4,
  localparam int IDX_W  = $clog2(N_ELEM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_ELEM*ELEM_W-1:0] in_data,
  input  logic [N_ELEM-1:0]        in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ELEM_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state, state_n;
  // agg_q holds the captured aggregate; rem_q holds the mask bits still to be
  // emitted after the beat currently presented on the output registers.
  logic [N_ELEM*ELEM_W-1:0]   agg_q, agg_n;
  logic [N_ELEM-1:0]          rem_q, rem_n;
  logic [ELEM_W-1:0]          data_q, data_n;
  logic [IDX_W-1:0]           idx_q, idx_n;
  logic                       last_q, last_n;

  logic                       accept, xfer, load;
  logic [N_ELEM-1:0]          src_mask, left;
  logic [N_ELEM*ELEM_W-1:0]   src_data;
  logic [IDX_W-1:0]           sel_idx;
  logic [ELEM_W-1:0]          sel_data;

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

  // A new aggregate may enter while idle or on the very edge the last beat leaves.
  assign in_ready = !rst && ((state == IDLE) || (out_valid && out_ready && last_q));
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Priority select of the lowest set bit, over either the incoming or the held mask.
  always_comb begin
    src_mask = accept ? in_mask : rem_q;
    src_data = accept ? in_data : agg_q;
    sel_idx  = '0;
    sel_data = '0;
    for (int i = N_ELEM - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        sel_idx  = IDX_W'(i);
        sel_data = src_data[i*ELEM_W +: ELEM_W];
      end
    end
    left = src_mask & (src_mask - N_ELEM'(1));
  end

  // Next-state: load the next beat on accept or on a non-final transfer.
  always_comb begin
    state_n = state;
    agg_n   = agg_q;
    rem_n   = rem_q;
    data_n  = data_q;
    idx_n   = idx_q;
    last_n  = last_q;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (in_mask != '0)) load = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          if (!last_q) begin
            load = 1'b1;
          end else if (accept && (in_mask != '0)) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            rem_n   = '0;
            data_n  = '0;
            idx_n   = '0;
            last_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = SEND;
      agg_n   = src_data;
      rem_n   = left;
      data_n  = sel_data;
      idx_n   = sel_idx;
      last_n  = (left == '0);
    end
  end

  // State and output registers; reset drops any aggregate in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      agg_q  <= '0;
      rem_q  <= '0;
      data_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      agg_q  <= agg_n;
      rem_q  <= rem_n;
      data_q <= data_n;
      idx_q  <= idx_n;
      last_q <= last_n;
    end
  end

endmodule

// File: tb/tb_pattern_unpacker.sv
// Scoreboard bench for pattern_unpacker: accepted aggregates are expanded into
// expected beats; a negedge monitor pops and compares each transferred beat.
module tb_pattern_unpacker;
  localparam int ELEM_W = 8;
  localparam int N_ELEM = 4;
  localparam int IDX_W  = $clog2(N_ELEM);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_ELEM*ELEM_W-1:0] in_data;
  logic [N_ELEM-1:0]        in_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [ELEM_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;

  pattern_unpacker #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [ELEM_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pops = 0;
  int acc_cyc = 0;
  int last_cyc = 0;
  bit hold_rdy = 1'b1;
  bit rst_q = 1'b0;
  bit prev_acc = 1'b0;
  bit prev_stall = 1'b0;
  logic [IDX_W-1:0]  pidx;
  logic [ELEM_W-1:0] pdata;
  logic              plast;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: masked-in elements in ascending index order, last on the final one.
  task automatic expand(input logic [N_ELEM*ELEM_W-1:0] d, input logic [N_ELEM-1:0] m);
    int total = 0;
    int k = 0;
    beat_t b;
    for (int i = 0; i < N_ELEM; i++) if (m[i]) total++;
    for (int i = 0; i < N_ELEM; i++) begin
      if (m[i]) begin
        k++;
        b.idx  = IDX_W'(i);
        b.data = d[i*ELEM_W +: ELEM_W];
        b.last = (k == total);
        q.push_back(b);
      end
    end
  endtask

  // Monitor: reset checks, latency, hold-stability, and scoreboard pops.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst_q)
      chk("reset_outputs", {out_valid, out_data, out_idx, out_last, busy}, '0);
    if (rst) begin
      chk("rst_in_ready", in_ready, 1'b0);
      q.delete();
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_acc) chk("first_beat_latency", out_valid, 1'b1);
      if (prev_stall)
        chk("pending_beat_stable", {out_valid, out_idx, out_data, out_last},
            {1'b1, pidx, pdata, plast});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {out_idx, out_data}, '0);
          fails += (tests > 0 && {out_idx, out_data} == '0) ? 1 : 0;
        end else begin
          e = q.pop_front();
          chk("beat", {out_idx, out_data, out_last}, {e.idx, e.data, e.last});
        end
        pops++;
        if (out_last) last_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        expand(in_data, in_mask);
        acc_cyc  = cyc;
        prev_acc = (in_mask != '0);
      end else begin
        prev_acc = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      pidx  = out_idx;
      pdata = out_data;
      plast = out_last;
    end
    rst_q = rst;
  end

  // Random consumer backpressure when not under directed control.
  always @(posedge clk) begin
    #1;
    if (!hold_rdy) out_ready = ($urandom_range(99) < 70);
  end

  task automatic send(input logic [N_ELEM*ELEM_W-1:0] d, input logic [N_ELEM-1:0] m);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("accept_in_time", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom} >> (64 - N_ELEM*ELEM_W);
    in_mask  = N_ELEM'($urandom);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int a_cyc;
    int base;
    logic [N_ELEM-1:0] m;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b1;

    // Reset / idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {in_ready, busy, out_valid}, 3'b100);

    // Full mask, then back-to-back single-element aggregate on the last beat
    @(posedge clk); #1;
    send(32'h44332211, 4'b1111);
    a_cyc = acc_cyc;
    send(32'h000000AA, 4'b0001);
    chk("b2b_accept_cycle", acc_cyc, a_cyc + 4);
    chk("b2b_on_last_beat", acc_cyc, last_cyc);
    wait_drain();
    @(negedge clk);
    chk("busy_after_full", busy, 1'b0);

    // Sparse mask with two cycles of backpressure on the first beat
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h44332211, 4'b1010);
    @(posedge clk); #1;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Zero mask: accepted, nothing emitted
    @(posedge clk); #1;
    send(32'h55667788, 4'b0000);
    repeat (4) begin
      @(negedge clk);
      chk("zero_mask_idle", {out_valid, in_ready, busy}, 3'b010);
    end

    // Reset after the second beat of a full aggregate
    @(posedge clk); #1;
    base = pops;
    send(32'h44332211, 4'b1111);
    for (int k = 0; k < 50; k++) begin
      if (pops >= base + 2) break;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_mid_reset", {in_ready, busy, out_valid}, 3'b100);
    @(posedge clk); #1;
    send(32'hDDCCBBAA, 4'b0110);
    wait_drain();

    // Random aggregates under random backpressure
    hold_rdy = 1'b0;
    repeat (40) begin
      m = N_ELEM'($urandom);
      if ($urandom_range(3) == 0) m = '0;
      send($urandom, m);
      repeat ($urandom_range(2)) @(posedge clk);
      #0;
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end
endmodule

// File: doc/pattern_unpacker.md
Name: pattern_unpacker

Overview:
- Reader side of the aggregate-pattern path: accepts one packed aggregate of N_ELEM elements plus a per-element valid mask in a single handshake.
- Emits the masked-in elements one per beat, in ascending index order, on a valid/ready stream.
- Sits between aggregate producers (register banks, configuration tables) and element-serial consumers.
- Masked-out elements count as "default-filled" and are skipped, never emitted.

Parameters:
- ELEM_W, 8, width of one element in bits (>=1).
- N_ELEM, 4, number of elements per aggregate (>=2).
- IDX_W (localparam), $clog2(N_ELEM), width of the element index.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  aggregate offered.
- in_ready  output  1  block can accept an aggregate this cycle.
- in_data  input  N_ELEM*ELEM_W  element i = in_data[i*ELEM_W +: ELEM_W].
- in_mask  input  N_ELEM  bit i = 1: element i is emitted; bit i = 0: element i is skipped.
- out_valid  output  1  element beat valid.
- out_ready  input  1  consumer accepts beat.
- out_data  output  ELEM_W  element value.
- out_idx  output  IDX_W  index of the emitted element.
- out_last  output  1  final beat of the current aggregate.
- busy  output  1  aggregate held, beats still pending.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. While rst is high, in_ready=0.
- A rst assertion mid-aggregate discards all remaining beats. No partial state survives.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready with in_mask!=0, capture in_data and in_mask, go to SEND.
  - IDLE with in_mask==0: the handshake completes, nothing is emitted, state stays IDLE (no beat, no out_last).
  - SEND: out_valid=1. out_idx = lowest set bit of the remaining mask. out_data = that element. out_last=1 iff no other remaining bit is set.
- Output beats and registers:
  - A beat transfers on out_valid&&out_ready. On transfer, clear that mask bit.
  - If the transferred beat had out_last=1, go to IDLE, unless a new aggregate is accepted in the same cycle.
  - out_data, out_idx and out_last are registered and stable while out_valid=1 and out_ready=0. Never change a pending beat.
- Latency and throughput:
  - First beat appears with out_valid=1 exactly one cycle after the accepting edge.
  - One beat per cycle while out_ready=1.
  - An aggregate with K set mask bits occupies exactly K cycles of SEND with out_ready held high.
- Back-to-back handoff:
  - in_ready = !rst && (state==IDLE || (out_valid && out_ready && out_last)). This is a combinational path from out_ready.
  - On a simultaneous last-beat transfer and new accept: a non-zero new mask goes directly to SEND, so its first beat arrives the next cycle with no bubble.
  - On a simultaneous last-beat transfer and new accept with a zero new mask: go to IDLE.
- busy=1 in SEND, 0 in IDLE.
- in_data and in_mask are don't-care except in the accepting cycle. A later change to them never affects a held aggregate.
- Edge cases:
  - in_valid asserted in SEND (not on the last beat): no accept; the producer holds.
  - Full mask emits indices 0..N_ELEM-1.
  - A single-bit mask gives one beat with out_last=1.
  - Highest index N_ELEM-1 with a non-power-of-two N_ELEM: out_idx never exceeds N_ELEM-1.
- Scan order is ascending. The priority select is combinational over the remaining mask, with no multicycle search.

Test Plan:
1. Reset/idle:
   - Stimulus: hold rst 3 cycles, then release.
   - Required: all outputs 0, in_ready=0 during rst; in_ready=1 and busy=0 the cycle after release.
2. Full mask, consumer always ready:
   - Stimulus: ELEM_W=8, N_ELEM=4, in_data=32'h44332211, in_mask=4'b1111, out_ready=1.
   - Required: beats (idx,data) = (0,11),(1,22),(2,33),(3,44) on 4 consecutive cycles; out_last only on idx 3; then busy=0.
3. Sparse mask with backpressure:
   - Stimulus: in_mask=4'b1010, data as in test 2; out_ready low 2 cycles on the first beat.
   - Required: (1,22) held stable 3 cycles, then (3,44) with out_last=1; indices 0 and 2 never appear.
4. Zero mask:
   - Stimulus: in_mask=4'b0000 accepted.
   - Required: no out_valid ever; in_ready stays 1; busy stays 0.
5. Back-to-back:
   - Stimulus: second aggregate (in_mask=4'b0001, data 8'hAA at idx 0) presented during the last beat of test 2.
   - Required: accepted in that cycle; (0,AA) with out_last=1 appears the next cycle, with no idle cycle.
6. Reset mid-aggregate:
   - Stimulus: assert rst after the second beat of test 2.
   - Required: out_valid=0 next cycle; after release, no residual beats; a fresh aggregate starts from its lowest set index.
